mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Byte-serial memory controller: responder for the MEM-stage load/store port and the IF-stage instruction-fetch port, driving a single synchronous 8-bit RAM. It arbitrates the two requesters and splits each 1/2/4-byte access into little-endian byte cycles. For loads it assembles and sign- or zero-extends the result, then returns a one-cycle ready pulse to the requester.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, requester data width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- mem_read  in  1  MEM-stage load request, held until mem_ready
- mem_write  in  1  MEM-stage store request, held until mem_ready
- mem_addr  in  ADDR_W  byte address of access
- mem_wdata  in  DATA_W  store data, low `length` bytes used
- mem_length  in  3  bytes: 1, 2, any other value = 4
- mem_signed  in  1  sign-extend load result (lengths 1, 2 only)
- mem_ready  out  1  one-cycle completion pulse for data port
- mem_rdata  out  DATA_W  load result, valid only while mem_ready=1
- if_read  in  1  fetch request (4 bytes, unsigned), held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_ready  out  1  one-cycle completion pulse for fetch port
- if_inst  out  DATA_W  fetched word, valid only while if_ready=1
- ram_a  out  ADDR_W  RAM byte address
- ram_dout  out  8  RAM write byte
- ram_din  in  8  RAM read byte, valid cycle after its address
- ram_wr  out  1  1 = write ram_dout at ram_a this cycle

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: data port (mem_read|mem_write) has priority over if_read. Latch addr, length, wdata, signed, and owner (DATA/IF). Go to READ or WRITE with cnt=0. With no request, stay.
- Same-cycle mem_read and mem_write: treat as read.
- READ, N bytes: in READ cycle k (k=1..N+1):
  - For k≤N, drive ram_a = addr+(k-1), ram_wr=0.
  - For k≥2, capture ram_din into bits [8(k-2)+7 : 8(k-2)].
  - After cycle N+1, go to DONE.
- WRITE, N bytes: in WRITE cycle k (k=1..N), drive ram_a=addr+(k-1), ram_dout=wdata byte k-1, ram_wr=1. After cycle N, go to DONE.
- DONE: assert owner's ready for exactly one cycle with the registered result, then go to IDLE.
- Extension: length 1 fills bits [31:8] with bit 7 if signed, else 0. Length 2 does the same from bit 15. Length 4 ignores signed.
- Address increment is modulo 2^ADDR_W; 0xFFFFFFFF+1 wraps to 0.
- Request fields are sampled only in IDLE; mid-transaction input changes are ignored. A requester dropping its request mid-transaction does not abort it; the ready pulse still occurs.
- A non-owner request waits in IDLE arbitration. The request seen in the cycle after DONE is a new transaction.

## Timing
- Reset values: state=IDLE, ram_a=0, ram_dout=0, ram_wr=0, mem_ready=0, if_ready=0, mem_rdata=0, if_inst=0.
- Outside their active cycles, ram_a, ram_dout and ram_wr are 0. All outputs are registered.
- Latency from accept cycle (cycle 0):
  - read of N bytes: ready in cycle N+2 (byte 3, word 6);
  - write of N bytes: ready in cycle N+1 (byte 2, word 5).
- Back-to-back: a request held after DONE is accepted in the following IDLE cycle. Minimum gap between ready pulses is one idle cycle.
- Reset mid-transaction: next cycle is IDLE with ram_wr=0 and no ready pulse. Bytes already written remain in RAM.

## Structure
- Add to define.v: `LenByte`=3'd1, `LenHalf`=3'd2, `LenWord`=3'd4, `RamDataBus` [7:0]. Reuse existing `MemAddrBus`, `MemDataBus`, `RegBus`.
- State encoding stays as localparams inside the module.
- Single module, no sub-module. Byte assembly and extension are an inline registered block.

## Test plan
- Word store then load: mem_write addr 0x100 data 0xDEADBEEF len 4 → RAM[0x100..0x103]=EF,BE,AD,DE, mem_ready in cycle 5. Then mem_read same address → mem_rdata=0xDEADBEEF in cycle 6.
- Byte extension: RAM[0x20]=0x80, load len 1 → signed gives 0xFFFFFF80, unsigned gives 0x00000080. Half at 0x20 with RAM[0x21]=0x7F, signed → 0x00007F80.
- Arbitration: if_read and mem_read asserted in the same cycle → data completes first, if_ready follows. if_ready never coincides with mem_ready.
- Wrap: word store at 0xFFFFFFFE → bytes written at 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- Reset during WRITE cycle 2 of a word store → only byte 0 and byte 1 written, ram_wr=0 next cycle, no mem_ready.
- Back-to-back loads held by a stalled requester → exactly one ready pulse per transaction, separated by one idle cycle.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared length codes, owner tag and helpers for the byte-serial memory controller.
package mem_ctrl_pkg;
  localparam logic [2:0] LEN_BYTE   = 3'd1;
  localparam logic [2:0] LEN_HALF   = 3'd2;
  localparam logic [2:0] LEN_WORD   = 3'd4;
  localparam int         RAM_DATA_W = 8;

  typedef enum logic {OWNER_DATA, OWNER_IF} owner_e;

  // Any length code other than byte/half means a full word.
  function automatic logic [2:0] len_bytes(input logic [2:0] len);
    if (len == LEN_BYTE) return LEN_BYTE;
    if (len == LEN_HALF) return LEN_HALF;
    return LEN_WORD;
  endfunction
endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates data and fetch ports onto an 8-bit synchronous RAM, one byte per cycle.
// N-byte read readies N+2 cycles after accept, write N+1; requests are held until the one-cycle ready.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic [2:0]            mem_length,
  input  logic                  mem_signed,
  output logic                  mem_ready,
  output logic [DATA_W-1:0]     mem_rdata,
  input  logic                  if_read,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_ready,
  output logic [DATA_W-1:0]     if_inst,
  output logic [ADDR_W-1:0]     ram_a,
  output logic [RAM_DATA_W-1:0] ram_dout,
  input  logic [RAM_DATA_W-1:0] ram_din,
  output logic                  ram_wr
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e                  state_q, state_d;
  owner_e                  owner_q, owner_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [2:0]              nbytes_q, nbytes_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [DATA_W-1:0]       buf_q, buf_d;
  logic                    signed_q, signed_d;
  logic [ADDR_W-1:0]       ram_a_q, ram_a_d;
  logic [RAM_DATA_W-1:0]   ram_dout_q, ram_dout_d;
  logic                    ram_wr_q, ram_wr_d;
  logic                    mem_ready_q, mem_ready_d;
  logic                    if_ready_q, if_ready_d;
  logic [DATA_W-1:0]       mem_rdata_q, mem_rdata_d;
  logic [DATA_W-1:0]       if_inst_q, if_inst_d;

  logic [ADDR_W-1:0]       next_a;
  logic [1:0]              rd_idx;
  logic [1:0]              wr_idx;

  // Address of the byte after the current one; wraps modulo 2^ADDR_W.
  assign next_a = addr_q + ADDR_W'(cnt_q) + ADDR_W'(1);
  // RAM data lags its address by one cycle, so read cycle k fills byte k-2.
  assign rd_idx = cnt_q[1:0] - 2'd1;
  assign wr_idx = cnt_q[1:0] + 2'd1;

  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] raw,
                                               input logic [2:0] n, input logic sgn);
    logic [DATA_W-1:0] r;
    r = raw;
    if (n == LEN_BYTE)      r = {{(DATA_W-8){sgn & raw[7]}}, raw[7:0]};
    else if (n == LEN_HALF) r = {{(DATA_W-16){sgn & raw[15]}}, raw[15:0]};
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    nbytes_d    = nbytes_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    signed_d    = signed_q;
    ram_a_d     = '0;
    ram_dout_d  = '0;
    ram_wr_d    = 1'b0;
    mem_ready_d = 1'b0;
    if_ready_d  = 1'b0;
    mem_rdata_d = mem_rdata_q;
    if_inst_d   = if_inst_q;
    unique case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          owner_d  = OWNER_DATA;
          addr_d   = mem_addr;
          nbytes_d = len_bytes(mem_length);
          wdata_d  = mem_wdata;
          signed_d = mem_signed;
          cnt_d    = '0;
          buf_d    = '0;
          ram_a_d  = mem_addr;
          if (mem_read) begin
            state_d = READ;
          end else begin
            state_d    = WRITE;
            ram_wr_d   = 1'b1;
            ram_dout_d = mem_wdata[7:0];
          end
        end else if (if_read) begin
          owner_d  = OWNER_IF;
          addr_d   = if_addr;
          nbytes_d = LEN_WORD;
          wdata_d  = '0;
          signed_d = 1'b0;
          cnt_d    = '0;
          buf_d    = '0;
          ram_a_d  = if_addr;
          state_d  = READ;
        end
      end
      READ: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q != 3'd0) buf_d[{rd_idx, 3'b000} +: 8] = ram_din;
        if (cnt_q + 3'd1 < nbytes_q) ram_a_d = next_a;
        if (cnt_q == nbytes_q) begin
          state_d = DONE;
          if (owner_q == OWNER_DATA) begin
            mem_ready_d = 1'b1;
            mem_rdata_d = extend(buf_d, nbytes_q, signed_q);
          end else begin
            if_ready_d = 1'b1;
            if_inst_d  = buf_d;
          end
        end
      end
      WRITE: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q + 3'd1 == nbytes_q) begin
          state_d     = DONE;
          mem_ready_d = 1'b1;
        end else begin
          ram_a_d    = next_a;
          ram_dout_d = wdata_q[{wr_idx, 3'b000} +: 8];
          ram_wr_d   = 1'b1;
        end
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWNER_DATA;
      addr_q      <= '0;
      nbytes_q    <= '0;
      cnt_q       <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      signed_q    <= 1'b0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      mem_ready_q <= 1'b0;
      if_ready_q  <= 1'b0;
      mem_rdata_q <= '0;
      if_inst_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      nbytes_q    <= nbytes_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      signed_q    <= signed_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      mem_ready_q <= mem_ready_d;
      if_ready_q  <= if_ready_d;
      mem_rdata_q <= mem_rdata_d;
      if_inst_q   <= if_inst_d;
    end
  end

  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  assign ram_wr    = ram_wr_q;
  assign mem_ready = mem_ready_q;
  assign if_ready  = if_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign if_inst   = if_inst_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: byte-array reference model, queued expectations, independent monitor.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write, mem_signed, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_length;
  logic        if_read, if_ready;
  logic [31:0] if_addr, if_inst;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout, ram_din;
  logic        ram_wr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_load;
    logic [31:0] val;
  } exp_t;
  exp_t        exp_data[$];
  logic [31:0] exp_if[$];
  exp_t        mon_e;

  bit [7:0]    model [bit [31:0]];
  logic [7:0]  ram_mem [0:8191] = '{default: 8'h00};
  int          wr_count = 0;
  int          exp_wr = 0;
  logic        prev_ready = 1'b0;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_length(mem_length), .mem_signed(mem_signed),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .if_read(if_read), .if_addr(if_addr), .if_ready(if_ready), .if_inst(if_inst),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_din(ram_din), .ram_wr(ram_wr)
  );

  function automatic int ridx(input logic [31:0] a);
    return int'({a[31], a[11:0]});
  endfunction

  // Synchronous byte RAM: read data appears the cycle after its address.
  always @(posedge clk) begin
    if (ram_wr) begin
      ram_mem[ridx(ram_a)] <= ram_dout;
      wr_count <= wr_count + 1;
    end
    ram_din <= ram_mem[ridx(ram_a)];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] len);
    return (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input int n, input bit sgn);
    logic [31:0] v;
    bit   [31:0] ad;
    v = '0;
    for (int i = 0; i < n; i++) begin
      ad = a + 32'(i);
      v = v | (32'(model.exists(ad) ? model[ad] : 8'h00) << (8 * i));
    end
    if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input int n, input logic [31:0] wd);
    for (int i = 0; i < n; i++) begin
      model[a + 32'(i)] = wd[8*i +: 8];
      exp_wr++;
    end
  endtask

  // Monitor: every ready pulse is matched against the head of its port's queue.
  always @(negedge clk) begin
    if (!reset && (mem_ready || if_ready)) begin
      chk("ready_overlap", 32'(mem_ready & if_ready), 32'd0);
      chk("ready_gap", 32'(prev_ready), 32'd0);
      if (mem_ready) begin
        if (exp_data.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_mem_ready: got pulse, required none");
        end else begin
          mon_e = exp_data.pop_front();
          if (mon_e.is_load) chk("mem_rdata", mem_rdata, mon_e.val);
        end
      end
      if (if_ready) begin
        if (exp_if.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_if_ready: got pulse, required none");
        end else begin
          chk("if_inst", if_inst, exp_if.pop_front());
        end
      end
    end
    prev_ready <= mem_ready | if_ready;
  end

  // Called at a negedge with the controller idle; returns at a negedge with it idle again.
  task automatic data_txn(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] len, input logic sgn,
                          input string name);
    int   n, lat;
    bit   got;
    exp_t e;
    n = nbytes(len);
    e.is_load = rd;
    e.val = '0;
    if (rd) e.val = model_load(a, n, sgn);
    else model_store(a, n, wd);
    exp_data.push_back(e);
    mem_read = rd; mem_write = wr; mem_addr = a; mem_wdata = wd;
    mem_length = len; mem_signed = sgn;
    got = 0; lat = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (mem_ready) got = 1;
      else if (lat == 1) begin
        mem_addr = $urandom; mem_wdata = $urandom;
        mem_length = 3'($urandom); mem_signed = 1'($urandom);
        if ($urandom_range(0, 3) == 0) begin mem_read = 0; mem_write = 0; end
      end
    end
    chk({name, "_latency"}, lat, rd ? n + 2 : n + 1);
    mem_read = 0; mem_write = 0;
    @(negedge clk);
  endtask

  task automatic if_txn(input logic [31:0] a, input string name);
    int lat;
    bit got;
    exp_if.push_back(model_load(a, 4, 0));
    if_read = 1; if_addr = a;
    got = 0; lat = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (if_ready) got = 1;
      else if (lat == 1) begin
        if_addr = $urandom;
        if ($urandom_range(0, 3) == 0) if_read = 0;
      end
    end
    chk({name, "_latency"}, lat, 6);
    if_read = 0;
    @(negedge clk);
  endtask

  task automatic arb_txn(input logic [31:0] ma, input logic [2:0] len, input logic sgn,
                         input logic [31:0] ia);
    int   n, t, tm, ti;
    exp_t e;
    n = nbytes(len);
    e.is_load = 1;
    e.val = model_load(ma, n, sgn);
    exp_data.push_back(e);
    exp_if.push_back(model_load(ia, 4, 0));
    mem_read = 1; mem_write = 0; mem_addr = ma; mem_length = len; mem_signed = sgn;
    if_read = 1; if_addr = ia;
    t = 0; tm = 0; ti = 0;
    while ((tm == 0 || ti == 0) && t < 60) begin
      @(negedge clk);
      t++;
      if (mem_ready && tm == 0) begin tm = t; mem_read = 0; end
      if (if_ready && ti == 0) begin ti = t; if_read = 0; end
    end
    chk("arb_mem_latency", tm, n + 2);
    chk("arb_if_latency", ti, n + 9);
    mem_read = 0; if_read = 0;
    @(negedge clk);
  endtask

  task automatic held_txn(input logic [31:0] a, input logic [2:0] len, input logic sgn);
    int   n, t, t1, t2;
    exp_t e;
    n = nbytes(len);
    e.is_load = 1;
    e.val = model_load(a, n, sgn);
    exp_data.push_back(e);
    exp_data.push_back(e);
    mem_read = 1; mem_write = 0; mem_addr = a; mem_length = len; mem_signed = sgn;
    t = 0; t1 = 0; t2 = 0;
    while (t2 == 0 && t < 60) begin
      @(negedge clk);
      t++;
      if (mem_ready) begin
        if (t1 == 0) t1 = t;
        else begin t2 = t; mem_read = 0; end
      end
    end
    chk("held_first_latency", t1, n + 2);
    chk("held_second_spacing", t2 - t1, n + 3);
    mem_read = 0;
    @(negedge clk);
  endtask

  task automatic reset_mid_write(input logic [31:0] a, input logic [31:0] wd);
    model_store(a, 2, wd);
    mem_write = 1; mem_read = 0; mem_addr = a; mem_wdata = wd; mem_length = 3'd4;
    @(negedge clk);
    @(negedge clk);
    reset = 1; mem_write = 0;
    @(negedge clk);
    chk("rst_ram_wr", 32'(ram_wr), 32'd0);
    chk("rst_mem_ready", 32'(mem_ready), 32'd0);
    chk("rst_ram_a", ram_a, 32'd0);
    reset = 0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 2))
      0:       return 32'h100 + 32'($urandom_range(0, 31));
      1:       return 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      default: return 32'h20 + 32'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    bit [31:0]   k;
    int          op;
    logic [31:0] a;
    reset = 1; mem_read = 0; mem_write = 0; mem_addr = '0; mem_wdata = '0;
    mem_length = '0; mem_signed = 0; if_read = 0; if_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_ready", 32'(mem_ready), 32'd0);
    chk("reset_if_ready", 32'(if_ready), 32'd0);
    chk("reset_mem_rdata", mem_rdata, 32'd0);
    chk("reset_if_inst", if_inst, 32'd0);
    chk("reset_ram_a", ram_a, 32'd0);
    chk("reset_ram_dout", 32'(ram_dout), 32'd0);
    chk("reset_ram_wr", 32'(ram_wr), 32'd0);
    reset = 0;

    data_txn(0, 1, 32'h100, 32'hDEAD_BEEF, 3'd4, 0, "word_store");
    data_txn(1, 0, 32'h100, 32'h0, 3'd4, 0, "word_load");
    data_txn(0, 1, 32'h20, 32'h0000_0080, 3'd1, 0, "byte_store_80");
    data_txn(0, 1, 32'h21, 32'h0000_007F, 3'd1, 0, "byte_store_7f");
    data_txn(1, 0, 32'h20, 32'h0, 3'd1, 1, "byte_load_signed");
    data_txn(1, 0, 32'h20, 32'h0, 3'd1, 0, "byte_load_unsigned");
    data_txn(1, 0, 32'h20, 32'h0, 3'd2, 1, "half_load_signed");
    data_txn(1, 0, 32'h102, 32'h0, 3'd2, 1, "half_load_neg");
    data_txn(1, 1, 32'h101, 32'h0, 3'd7, 1, "rdwr_as_read");
    arb_txn(32'h20, 3'd4, 0, 32'h100);
    data_txn(0, 1, 32'hFFFF_FFFE, 32'h1122_3344, 3'd4, 0, "wrap_store");
    data_txn(1, 0, 32'hFFFF_FFFE, 32'h0, 3'd4, 0, "wrap_load");
    if_txn(32'hFFFF_FFFF, "wrap_fetch");
    reset_mid_write(32'h200, 32'hA1B2_C3D4);
    data_txn(1, 0, 32'h200, 32'h0, 3'd4, 0, "after_reset_load");
    held_txn(32'h100, 3'd2, 0);

    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 4);
      a = rand_addr();
      case (op)
        0: data_txn(0, 1, a, $urandom, 3'($urandom), 1'($urandom), "rnd_store");
        1: data_txn(1, 0, a, $urandom, 3'($urandom), 1'($urandom), "rnd_load");
        2: if_txn(a, "rnd_fetch");
        3: data_txn(1, 1, a, $urandom, 3'($urandom), 1'($urandom), "rnd_rdwr");
        default: arb_txn(a, 3'($urandom), 1'($urandom), rand_addr());
      endcase
    end

    repeat (3) @(negedge clk);
    chk("exp_data_drained", 32'(exp_data.size()), 32'd0);
    chk("exp_if_drained", 32'(exp_if.size()), 32'd0);
    chk("ram_write_count", 32'(wr_count), 32'(exp_wr));
    if (model.first(k)) begin
      do chk("ram_byte", 32'(ram_mem[ridx(k)]), 32'(model[k]));
      while (model.next(k));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end
endmodule
